sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised single-clock FIFO with registered status flags, an occupancy count, programmable almost-full and almost-empty thresholds, and overflow/underflow error pulses. It is the general-purpose buffer between producer and consumer logic in one clock domain. Data width, depth and thresholds are set per instance. Reads return data one cycle after acceptance, marked by a valid strobe.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries (ADDR_W ≥ 1)
- AFULL_TH, 2**ADDR_W-2, almost_full asserts when count ≥ AFULL_TH (1..DEPTH)
- AEMPTY_TH, 2, almost_empty asserts when count ≤ AEMPTY_TH (0..DEPTH-1)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  write request
- data_in  in  DATA_W  write data
- rd_en  in  1  read request
- data_out  out  DATA_W  read data, registered
- rd_valid  out  1  data_out updated this cycle (one-cycle pulse)
- count  out  ADDR_W+1  current occupancy, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count ≤ AEMPTY_TH
- almost_full  out  1  count ≥ AFULL_TH
- overflow  out  1  one-cycle pulse: write request while full
- underflow  out  1  one-cycle pulse: read request while empty

## Operation
- Reset (rst=1, asynchronous): wr_ptr=rd_ptr=0, count=0, data_out=0, rd_valid=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=underflow=0. Memory contents are not reset.
- Write accept: wr_acc = wr_en & ~full. On accept, mem[wr_ptr] ← data_in and wr_ptr ← wr_ptr+1 (mod DEPTH).
- Read accept: rd_acc = rd_en & ~empty. On accept, data_out ← mem[rd_ptr], rd_valid ← 1 and rd_ptr ← rd_ptr+1 (mod DEPTH). Otherwise rd_valid ← 0 and data_out holds.
- Acceptance uses the registered flags at the start of the cycle, never combinational lookahead.
- Count update: count_next = count + wr_acc − rd_acc, using ADDR_W+1 bits with no wrap.
- All four status flags are registered and computed from count_next, so they are consistent with count every cycle.
- Simultaneous read and write:
  - Neither full nor empty: both are accepted and count is unchanged.
  - Full: only the read is accepted. count drops to DEPTH−1 and overflow pulses.
  - Empty: only the write is accepted. count becomes 1, no read data is returned, and underflow pulses.
- Rejected requests:
  - overflow ← wr_en & full.
  - underflow ← rd_en & empty.
  - Each is a one-cycle registered pulse. A rejected request does not change the pointers, the memory or data_out.
- Pointers wrap from DEPTH−1 to 0. Ordering is strict FIFO across the wrap.
- Reset mid-operation: all state returns to reset values immediately. Stored data is treated as lost.

## Timing
- Read latency: with rd_en high at edge N and the FIFO non-empty, data_out and rd_valid=1 are visible after edge N.
- Write-to-read: a word written at edge N makes empty=0 after edge N. The earliest read request is at edge N+1, with data after that edge.
- Flags and count change only on the clock edge, or asynchronously on reset.
- Maximum sustained throughput is one write plus one read per cycle.

## Test plan
- Reset, then fill (DATA_W=8, ADDR_W=4) by writing 0x00..0x0F on consecutive cycles:
  - almost_full rises when count reaches 14.
  - full=1 and count=16 after the 16th write.
  - A 17th write gives overflow=1 for one cycle, and the contents are unchanged.
- Drain a full FIFO:
  - data_out goes 0x00..0x0F in order, each with rd_valid=1.
  - almost_empty rises at count=2; empty=1 after the 16th read.
  - A further rd_en gives underflow=1 for one cycle, rd_valid=0, and data_out holds 0x0F.
- Wrap-around: write 10, read 10, then write 12 (0xA0..0xAB) and read 12. Data returns in order across the pointer wrap, and count ends at 0.
- Simultaneous read and write:
  - At count=5: count stays 5 and data order is preserved.
  - At full: count becomes 15, with an overflow pulse.
  - At empty: count becomes 1, with an underflow pulse and rd_valid=0.
- Assert rst asynchronously (between edges) with count=7. All outputs take reset values immediately, and the next write/read returns the newly written data.
- Thresholds: with ADDR_W=3, AFULL_TH=6, AEMPTY_TH=1, step count 0→8→0. almost_empty=1 exactly for count ≤1, and almost_full=1 exactly for count ≥6.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered count and status flags and overflow/underflow pulses.
// Read data appears one cycle after an accepted rd_en; requests made while full or empty are dropped.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = 2**ADDR_W - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_acc;
  logic              rd_acc;
  logic [ADDR_W:0]   count_next;

  // Acceptance looks only at the registered flags, so there is no combinational path from rd_en to write acceptance.
  assign wr_acc     = wr_en & ~full;
  assign rd_acc     = rd_en & ~empty;
  assign count_next = count + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_out     <= '0;
      rd_valid     <= 1'b0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + ADDR_W'(1);
        data_out <= mem[rd_ptr];
      end
      rd_valid     <= rd_acc;
      count        <= count_next;
      // Flags come from count_next so they always agree with the registered count.
      empty        <= (count_next == '0);
      full         <= (count_next == DEPTH_C);
      almost_empty <= (count_next <= AEMPTY_C);
      almost_full  <= (count_next >= AFULL_C);
      overflow     <= wr_en & full;
      underflow    <= rd_en & empty;
    end
  end
endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;
  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, rd_en;
  logic [7:0] data_in, data_out;
  logic       rd_valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] count;

  logic       wr2, rd2;
  logic [7:0] din2, dout2;
  logic       rv2, e2, f2, ae2, af2, of2, uf2;
  logic [3:0] cnt2;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb[$];
  logic [7:0] last_d;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .AFULL_TH(14), .AEMPTY_TH(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .rd_valid(rd_valid), .count(count), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_param #(.DATA_W(8), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(1)) dut_th (
    .clk(clk), .rst(rst), .wr_en(wr2), .data_in(din2), .rd_en(rd2),
    .data_out(dout2), .rd_valid(rv2), .count(cnt2), .empty(e2), .full(f2),
    .almost_empty(ae2), .almost_full(af2), .overflow(of2), .underflow(uf2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the queue model predicts every output after the edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    logic was_full, was_empty, racc;
    logic [7:0] exp_d;
    int n;
    exp_d     = 8'h00;
    was_full  = (sb.size() == 16);
    was_empty = (sb.size() == 0);
    racc      = r & ~was_empty;
    wr_en = w; data_in = d; rd_en = r;
    if (racc) exp_d = sb.pop_front();
    if (w && !was_full) sb.push_back(d);
    @(posedge clk); #1;
    n = sb.size();
    check("rd_valid", rd_valid, racc);
    if (racc) begin
      check("data_out", data_out, exp_d);
      last_d = exp_d;
    end else begin
      check("data_hold", data_out, last_d);
    end
    check("count", count, n);
    check("empty", empty, n == 0);
    check("full", full, n == 16);
    check("almost_full", almost_full, n >= 14);
    check("almost_empty", almost_empty, n <= 2);
    check("overflow", overflow, w & was_full);
    check("underflow", underflow, r & was_empty);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_full"}, full, 0);
    check({tag, "_aempty"}, almost_empty, 1);
    check({tag, "_afull"}, almost_full, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_udf"}, underflow, 0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    wr2 = 1'b0; rd2 = 1'b0; din2 = '0;
    last_d = 8'h00;
    #12;
    check_reset_outputs("rst0");
    rst = 1'b0;

    // Fill 0x00..0x0F, then a 17th write overflows.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0);
    cyc(1'b1, 8'hEE, 1'b0);
    // Drain in order, then underflow with data_out holding 0x0F.
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    check("drain_last", data_out, 8'h0F);

    // Wrap-around across the pointer boundary.
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 12; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 8'h00, 1'b1);

    // Simultaneous read/write at count 5, at full and at empty.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h50 + 8'(i), 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b1);
    for (int i = 0; i < 11; i++) cyc(1'b1, 8'h70 + 8'(i), 1'b0);
    cyc(1'b1, 8'hDD, 1'b1);
    for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'hC3, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);

    // Threshold instance: step count 0 -> 8 -> 0.
    check("th_cnt0", cnt2, 0);
    check("th_ae0", ae2, 1);
    for (int i = 0; i < 16; i++) begin
      int c2;
      wr2 = (i < 8); rd2 = (i >= 8); din2 = 8'(i);
      @(posedge clk); #1;
      c2 = (i < 8) ? i + 1 : 15 - i;
      check("th_cnt", cnt2, c2);
      check("th_aempty", ae2, c2 <= 1);
      check("th_afull", af2, c2 >= 6);
      check("th_full", f2, c2 == 8);
    end
    wr2 = 1'b0; rd2 = 1'b0;

    // Asynchronous reset between edges with seven entries stored.
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'h90 + 8'(i), 1'b0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("arst");
    sb.delete();
    last_d = 8'h00;
    #1 rst = 1'b0;
    cyc(1'b1, 8'h5A, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    check("post_rst_data", data_out, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
